// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector (MSB of PATTERN received first).
// State = number of pattern bits currently matched (0..PATTERN_LEN).
// Transitions come from a table built at elaboration time with KMP
// fallback semantics, so the runtime logic is only a table lookup.
// MOORE selects registered (1) or combinational (0) match timing.
// OVERLAP selects whether a full match may seed the next one.
// Optional macro SEQDET_COUNT_EN adds a saturating match_count output.
module seq_detector_param #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
  parameter int                     MOORE       = 0,
  parameter int                     OVERLAP     = 1,
  parameter int                     COUNT_W     = 8,
  parameter int                     ST_W        = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            x,
  input  logic            in_valid,
  output logic            match,
  output logic [ST_W-1:0] state_dbg
`ifdef SEQDET_COUNT_EN
  ,
  output logic [COUNT_W-1:0] match_count
`endif
);

  localparam logic [ST_W-1:0] FULL = ST_W'(PATTERN_LEN);

  // Reject configurations the state encoding cannot represent.
  if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_len_chk
    $error("seq_detector_param: PATTERN_LEN must be within 2..16");
  end
  if ((1 << ST_W) <= PATTERN_LEN) begin : g_stw_chk
    $error("seq_detector_param: ST_W too narrow for PATTERN_LEN");
  end

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic int pbit(input int i);
    logic [PATTERN_LEN-1:0] tmp;
    tmp = PATTERN >> (PATTERN_LEN - 1 - i);
    return int'(tmp[0]);
  endfunction

  // Next state after accepting bit b with s pattern bits matched: the
  // longest pattern prefix that is a suffix of (prefix_s followed by b).
  // For s = PATTERN_LEN this is exactly the prefix-function fallback.
  function automatic int nxt_f(input int s, input int b);
    int  n;
    int  r;
    int  idx;
    int  tb;
    bit  ok;
    r = 0;
    n = s + 1;
    for (int k = 1; k <= PATTERN_LEN; k++) begin
      if (k <= n) begin
        ok = 1'b1;
        for (int m = 0; m < k; m++) begin
          idx = n - k + m;
          tb  = (idx < s) ? pbit(idx) : b;
          if (tb != pbit(m)) ok = 1'b0;
        end
        if (ok) r = k;
      end
    end
    return r;
  endfunction

  logic [ST_W-1:0] tbl0 [PATTERN_LEN+1];
  logic [ST_W-1:0] tbl1 [PATTERN_LEN+1];

  // Without overlap, a completed match restarts as if from the empty state.
  for (genvar gs = 0; gs <= PATTERN_LEN; gs++) begin : g_tbl
    localparam int SRC = (gs == PATTERN_LEN && OVERLAP == 0) ? 0 : gs;
    assign tbl0[gs] = ST_W'(nxt_f(SRC, 0));
    assign tbl1[gs] = ST_W'(nxt_f(SRC, 1));
  end

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;
  logic [ST_W-1:0] acc0;
  logic [ST_W-1:0] acc1;
  logic [ST_W-1:0] acc;
  logic            detect;

  // Look up both candidate successors of the current state.
  always_comb begin
    acc0 = '0;
    acc1 = '0;
    for (int s = 0; s <= PATTERN_LEN; s++) begin
      if (state == ST_W'(s)) begin
        acc0 = tbl0[s];
        acc1 = tbl1[s];
      end
    end
  end

  // Next state and detection; an unqualified bit (even X) leaves state alone.
  always_comb begin
    acc       = x ? acc1 : acc0;
    state_nxt = state;
    if (in_valid) state_nxt = acc;
    detect    = in_valid & (acc == FULL);
  end

  // State register; reset drops any partial match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= '0;
    else        state <= state_nxt;
  end

  assign state_dbg = state;
  assign match     = (MOORE != 0) ? (state == FULL) : detect;

`ifdef SEQDET_COUNT_EN
  logic [COUNT_W-1:0] cnt;

  // Saturating count of detections; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= '0;
    else if (detect && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign match_count = cnt;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: four instances share one stimulus stream.
//   A: 1101 Mealy overlap   B: 1101 Mealy no-overlap
//   C: 1101 Moore overlap   D: 1111 Mealy overlap, COUNT_W = 2
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0;
  logic in_valid = 1'b0;

  logic       m_a, m_b, m_c, m_d;
  logic [4:0] s_a, s_b, s_c, s_d;
`ifdef SEQDET_COUNT_EN
  logic [7:0] c_a, c_b, c_c;
  logic [1:0] c_d;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .MOORE(0), .OVERLAP(1),
                       .COUNT_W(8), .ST_W(5)) u_a (
    .clk(clk), .reset(rst_n), .x(x), .in_valid(in_valid), .match(m_a), .state_dbg(s_a)
`ifdef SEQDET_COUNT_EN
    , .match_count(c_a)
`endif
  );

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .MOORE(0), .OVERLAP(0),
                       .COUNT_W(8), .ST_W(5)) u_b (
    .clk(clk), .reset(rst_n), .x(x), .in_valid(in_valid), .match(m_b), .state_dbg(s_b)
`ifdef SEQDET_COUNT_EN
    , .match_count(c_b)
`endif
  );

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1101), .MOORE(1), .OVERLAP(1),
                       .COUNT_W(8), .ST_W(5)) u_c (
    .clk(clk), .reset(rst_n), .x(x), .in_valid(in_valid), .match(m_c), .state_dbg(s_c)
`ifdef SEQDET_COUNT_EN
    , .match_count(c_c)
`endif
  );

  seq_detector_param #(.PATTERN_LEN(4), .PATTERN(4'b1111), .MOORE(0), .OVERLAP(1),
                       .COUNT_W(2), .ST_W(5)) u_d (
    .clk(clk), .reset(rst_n), .x(x), .in_valid(in_valid), .match(m_d), .state_dbg(s_d)
`ifdef SEQDET_COUNT_EN
    , .match_count(c_d)
`endif
  );

  typedef struct {
    logic x;
    logic v;
    logic a_m;   // A match before the edge (Mealy)
    int   a_s;   // A state after the edge
    logic b_m;
    int   b_s;
    logic c_m;   // C match after the edge (Moore)
    int   c_s;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Present a bit mid-cycle; combinational outputs settle before the edge.
  task automatic apply(input logic xb, input logic vb);
    @(negedge clk);
    x = xb;
    in_valid = vb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    //                x     v     a_m   a_s b_m   b_s c_m   c_s
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1, 1'b0, 1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 2, 1'b0, 2};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 3, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 4, 1'b1, 4, 1'b1, 4};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 2, 1'b0, 1, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 3};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 4, 1'b0, 1, 1'b1, 4};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 4, 1'b0, 1, 1'b1, 4};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0};

    // Reset state while the clock runs.
    x = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state_a", 32'(s_a), 0);
    chk("rst_state_c", 32'(s_c), 0);
    chk("rst_match_a", 32'(m_a), 0);
    chk("rst_match_c", 32'(m_c), 0);
`ifdef SEQDET_COUNT_EN
    chk("rst_count_a", 32'(c_a), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Main stream 1,1,0,1,1,0,1 then a gap and a mismatching bit.
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].x, vecs[i].v);
      chk($sformatf("v%0d_match_a", i), 32'(m_a), 32'(vecs[i].a_m));
      chk($sformatf("v%0d_match_b", i), 32'(m_b), 32'(vecs[i].b_m));
      tick();
      chk($sformatf("v%0d_state_a", i), 32'(s_a), 32'(vecs[i].a_s));
      chk($sformatf("v%0d_state_b", i), 32'(s_b), 32'(vecs[i].b_s));
      chk($sformatf("v%0d_state_c", i), 32'(s_c), 32'(vecs[i].c_s));
      chk($sformatf("v%0d_match_c", i), 32'(m_c), 32'(vecs[i].c_m));
    end
`ifdef SEQDET_COUNT_EN
    chk("stream_count_a", 32'(c_a), 2);
    chk("stream_count_b", 32'(c_b), 1);
    chk("stream_count_c", 32'(c_c), 2);
`endif

    // Gapped input with toggling and unknown x while in_valid is low.
    do_reset();
    apply(1'b1, 1'b1); tick();
    apply(1'b1, 1'b1); tick();
    chk("gap_pre_state", 32'(s_a), 2);
    for (int g = 0; g < 3; g++) begin
      apply((g == 1) ? 1'bx : ((g == 0) ? 1'b0 : 1'b1), 1'b0);
      chk($sformatf("gap%0d_match", g), 32'(m_a), 0);
      tick();
      chk($sformatf("gap%0d_state", g), 32'(s_a), 2);
    end
    apply(1'b0, 1'b1);
    chk("gap_bit3_match", 32'(m_a), 0);
    tick();
    chk("gap_bit3_state", 32'(s_a), 3);
    apply(1'b1, 1'b1);
    chk("gap_bit4_match", 32'(m_a), 1);
    tick();
    chk("gap_bit4_state", 32'(s_a), 4);

    // Reset asserted mid-pattern, between clock edges.
    do_reset();
    apply(1'b1, 1'b1); tick();
    apply(1'b1, 1'b1); tick();
    apply(1'b0, 1'b1); tick();
    chk("mid_pre_state", 32'(s_a), 3);
    @(negedge clk);
    x = 1'b1;
    in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_state_a", 32'(s_a), 0);
    chk("mid_rst_state_c", 32'(s_c), 0);
    chk("mid_rst_match_a", 32'(m_a), 0);
    chk("mid_rst_match_c", 32'(m_c), 0);
`ifdef SEQDET_COUNT_EN
    chk("mid_rst_count_a", 32'(c_a), 0);
`endif
    #1 rst_n = 1'b1;
    #1;
    chk("mid_post_match", 32'(m_a), 0);
    tick();
    chk("mid_post_state", 32'(s_a), 1);

    // Saturation: pattern 1111, ten ones, 2-bit counter.
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      apply(1'b1, 1'b1);
      chk($sformatf("sat%0d_match", i), 32'(m_d), (i >= 4) ? 1 : 0);
      tick();
      chk($sformatf("sat%0d_state", i), 32'(s_d), (i >= 4) ? 4 : i);
`ifdef SEQDET_COUNT_EN
      chk($sformatf("sat%0d_count", i), 32'(c_d), (i <= 3) ? 0 : ((i - 3 > 3) ? 3 : i - 3));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
